// File: rtl/regbank_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : regbank_bist_if
// Purpose  : Write/read port bundle between the BIST initiator and the bank.
// Revision : 1.0
// ============================================================================
interface regbank_bist_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          write;
    logic [AW-1:0] dr;
    logic [DW-1:0] wrData;
    logic [AW-1:0] sr1;
    logic [AW-1:0] sr2;
    logic [DW-1:0] rdData1;
    logic [DW-1:0] rdData2;

    modport master (
        output write, dr, wrData, sr1, sr2,
        input  rdData1, rdData2
    );

    modport slave (
        input  write, dr, wrData, sr1, sr2,
        output rdData1, rdData2
    );
endinterface
`default_nettype wire

// File: rtl/regbank_bist.sv
`default_nettype none
// ============================================================================
// Module   : regbank_bist
// Purpose  : Two-pass (true/inverted) write-then-pairwise-readback self-test
//            of a 2R/1W register bank with error count and first failure.
// Revision : 1.0
// ============================================================================
module regbank_bist #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREGS = 32,
    parameter int MULT  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    regbank_bist_if.master  bank,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [AW+1:0]   err_count,
    output logic [AW-1:0]   first_fail_reg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_last_wr = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_last_rd = AW'(NREGS / 2 - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic            r_pass;
    logic            w_pass_nxt;
    logic            w_accept;

    logic [DW-1:0]   w_exp1;
    logic [DW-1:0]   w_exp2;
    logic            w_mis1;
    logic            w_mis2;
    logic [AW-1:0]   w_sr1_nxt;
    logic [AW-1:0]   w_sr2_nxt;
    logic [AW+1:0]   w_err_sum;

    function automatic logic [DW-1:0] f_exp(input logic [AW-1:0] k, input logic p);
        logic [DW-1:0] v;
        v = DW'(k) * DW'(MULT);
        return p ? ~v : v;
    endfunction

    // The read selects currently on the bus identify what rdData1/2 must hold.
    always_comb begin
        w_exp1    = f_exp(bank.sr1, r_pass);
        w_exp2    = f_exp(bank.sr2, r_pass);
        w_mis1    = (r_state == S_READ) && (bank.rdData1 != w_exp1);
        w_mis2    = (r_state == S_READ) && (bank.rdData2 != w_exp2);
        w_err_sum = err_count + (AW+2)'(w_mis1) + (AW+2)'(w_mis2);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pass_nxt  = r_pass;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WRITE;
                    w_idx_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                end
            end
            S_WRITE: begin
                if (r_idx == c_last_wr) begin
                    w_state_nxt = S_READ;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_READ: begin
                if (r_idx == c_last_rd) begin
                    w_idx_nxt = '0;
                    if (!r_pass) begin
                        w_state_nxt = S_WRITE;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_sr1_nxt = '0;
        w_sr2_nxt = '0;
        if (w_state_nxt == S_READ) begin
            w_sr1_nxt = {w_idx_nxt[AW-2:0], 1'b0};
            w_sr2_nxt = {w_idx_nxt[AW-2:0], 1'b1};
        end
    end

    // Bank-side outputs are registered from the next state, so they line up
    // with the cycle the state machine is in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_pass         <= 1'b0;
            bank.write     <= 1'b0;
            bank.dr        <= '0;
            bank.wrData    <= '0;
            bank.sr1       <= '0;
            bank.sr2       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            err_count      <= '0;
            first_fail_reg <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_pass      <= w_pass_nxt;
            bank.write  <= (w_state_nxt == S_WRITE);
            bank.dr     <= (w_state_nxt == S_WRITE) ? w_idx_nxt : '0;
            bank.wrData <= (w_state_nxt == S_WRITE) ? f_exp(w_idx_nxt, w_pass_nxt) : '0;
            bank.sr1    <= w_sr1_nxt;
            bank.sr2    <= w_sr2_nxt;
            busy        <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ);
            done        <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                fail           <= 1'b0;
                err_count      <= '0;
                first_fail_reg <= '0;
            end else if (r_state == S_READ) begin
                err_count <= w_err_sum;
                if (!fail && (w_mis1 || w_mis2)) begin
                    fail           <= 1'b1;
                    first_fail_reg <= w_mis1 ? bank.sr1 : bank.sr2;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regbank_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_bist
// Purpose  : Bank model with injectable faults driving regbank_bist.
// Revision : 1.0
// ============================================================================
module tb_regbank_bist;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 32;
    localparam int MULT  = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic            fail;
    logic [AW+1:0]   err_count;
    logic [AW-1:0]   first_fail_reg;

    int checks   = 0;
    int failures = 0;

    regbank_bist_if #(.AW(AW), .DW(DW)) bif ();

    regbank_bist #(.AW(AW), .DW(DW), .NREGS(NREGS), .MULT(MULT)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bank           (bif),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .err_count      (err_count),
        .first_fail_reg (first_fail_reg)
    );

    always #5 clk = ~clk;

    // Bank model with a single stuck-at cell and optional dead read ports.
    logic [DW-1:0] mem [NREGS];
    bit  stuck_en;
    int  stuck_reg;
    int  stuck_bit;
    bit  stuck_val;
    bit  zero1;
    bit  zero2;

    function automatic logic [DW-1:0] faulty(input int k, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (stuck_en && k == stuck_reg) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bif.write) mem[bif.dr] <= faulty(int'(bif.dr), bif.wrData);
    end

    assign bif.rdData1 = zero1 ? '0 : mem[bif.sr1];
    assign bif.rdData2 = zero2 ? '0 : mem[bif.sr2];

    function automatic logic [DW-1:0] pat(input int k, input int p);
        logic [DW-1:0] v;
        v = DW'(k * MULT);
        return (p != 0) ? ~v : v;
    endfunction

    // Reference: each pass fully rewrites the bank, then reads ascending
    // registers; the first register whose readback differs is the first fail.
    task automatic model(output bit f, output int ec, output int ffr);
        int            first;
        logic [DW-1:0] seen;
        first = -1;
        ec    = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NREGS; k++) begin
                seen = faulty(k, pat(k, p));
                if (((k % 2) == 0) ? zero1 : zero2) seen = '0;
                if (seen != pat(k, p)) begin
                    ec++;
                    if (first < 0) first = k;
                end
            end
        end
        f   = (first >= 0);
        ffr = (first >= 0) ? first : 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_bank"}, {62'd0, bif.write, 1'b0} | 64'(bif.dr) | 64'(bif.wrData)
                           | 64'(bif.sr1) | 64'(bif.sr2), 64'd0);
        chk({nm, "_status"}, {busy, done, fail, err_count, first_fail_reg}, 64'd0);
    endtask

    // Launch one run and check timing profile and results.
    task automatic run_check(input string nm, input bit ef, input int eec,
                             input int effr, input int pulse_cyc);
        int cyc;
        int done_cyc;
        int bad_busy;
        bit wr_ok;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        bad_busy = 0;
        wr_ok    = (bif.write === 1'b1) && (bif.dr === '0) && (bif.wrData === pat(0, 0));
        while (cyc <= 200) begin
            start = (cyc == pulse_cyc);
            if ((busy !== 1'(cyc <= 96)) && bad_busy == 0) bad_busy = cyc;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_first_write"}, 64'(wr_ok), 64'd1);
        chk({nm, "_busy_bad_cycle"}, 64'(bad_busy), 64'd0);
        chk({nm, "_done_cycle"}, 64'(done_cyc), 64'd97);
        chk({nm, "_fail"}, 64'(fail), 64'(ef));
        chk({nm, "_err_count"}, 64'(err_count), 64'(eec));
        chk({nm, "_first_fail_reg"}, 64'(first_fail_reg), 64'(effr));
        @(negedge clk);
        chk({nm, "_done_pulse_hold"}, {done, busy, fail, err_count},
            {1'b0, 1'b0, ef, 7'(eec)});
    endtask

    typedef struct {
        string name;
        bit    s_en;
        int    s_reg;
        int    s_bit;
        bit    s_val;
        bit    z1;
        bit    z2;
        bit    e_fail;
        int    e_ec;
        int    e_ffr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  bad;
        bit  mf;
        int  mec;
        int  mffr;

        vecs[0] = '{"clean",      1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0};
        vecs[1] = '{"r5b0_sa0",   1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 5};
        vecs[2] = '{"port2_zero", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32, 1};
        vecs[3] = '{"both_zero",  1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 63, 1};

        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        stuck_en = 0; stuck_reg = 0; stuck_bit = 0; stuck_val = 0;
        zero1 = 0; zero2 = 0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_state");

        start = 1'b1;
        @(negedge clk);
        chk("start_under_reset_busy", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_busy", 64'(busy), 64'd0);

        for (int v = 0; v < 4; v++) begin
            stuck_en  = vecs[v].s_en;
            stuck_reg = vecs[v].s_reg;
            stuck_bit = vecs[v].s_bit;
            stuck_val = vecs[v].s_val;
            zero1     = vecs[v].z1;
            zero2     = vecs[v].z2;
            run_check(vecs[v].name, vecs[v].e_fail, vecs[v].e_ec, vecs[v].e_ffr, -1);
            if (v == 0) begin
                bad = 0;
                for (int k = 0; k < NREGS; k++) if (mem[k] !== pat(k, 1)) bad++;
                chk("clean_bank_contents_bad", 64'(bad), 64'd0);
                chk("clean_bank_reg3", 64'(mem[3]), 64'hFFFF_FFE1);
            end
        end
        stuck_en = 0; zero1 = 0; zero2 = 0;

        // A start pulse mid-run must not disturb the run.
        run_check("pulse_c40", 1'b0, 0, 0, 40);

        // Start held high: rerun is accepted in the IDLE cycle after DONE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < 200 && done !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_done_cycle", 64'(cyc), 64'd97);
        @(negedge clk);
        chk("held_c98", {bif.write, busy, done}, {1'b0, 1'b0, 1'b0});
        @(negedge clk);
        chk("held_c99", {bif.write, busy, 59'd0, bif.dr}, {1'b1, 1'b1, 59'd0, 5'd0});
        start = 1'b0;
        cyc = 0;
        while (cyc < 200 && done !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_run2_done", 64'(done), 64'd1);
        chk("held_run2_clean", {fail, err_count}, 64'd0);
        @(negedge clk);

        // Reset during pass-0 readback with both ports dead.
        zero1 = 1; zero2 = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_reset_err_count", 64'(err_count), 64'd13);
        reset = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_run_reset");
        reset = 1'b0;
        zero1 = 0; zero2 = 0;
        run_check("after_reset", 1'b0, 0, 0, -1);

        for (int r = 0; r < 10; r++) begin
            stuck_en  = 1'($urandom_range(0, 1));
            stuck_reg = int'($urandom_range(0, NREGS - 1));
            stuck_bit = int'($urandom_range(0, DW - 1));
            stuck_val = 1'($urandom_range(0, 1));
            zero1     = ($urandom_range(0, 7) == 0);
            zero2     = ($urandom_range(0, 7) == 0);
            model(mf, mec, mffr);
            run_check($sformatf("rand%0d", r), mf, mec, mffr, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
